alu_control_mc: RTL and testbench
=================================

# alu_control_mc

Parametrised, multi-cycle successor to the single-cycle ALU control decoder. Decodes the full RV32I/RV64I ALU operation set (R-type and I-type, including shifts and compares) into a 4-bit ALU control code. It adds an iterative M-extension multiply/divide engine. It sits in the execute stage between the main control unit and the ALU, and raises `stall` so the datapath holds the PC and pipeline registers while a multi-cycle M-op completes.

## Interface
Parameters:
- `XLEN`, 32, operand/result width (32 or 64).

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ALUOp`  in  2  00 load/store (ADD), 01 branch (SUB), 10 R-type, 11 I-type ALU.
- `func7`  in  7  instr[31:25].
- `func3`  in  3  instr[14:12].
- `valid`  in  1  instruction present in execute this cycle.
- `op_a`, `op_b`  in  XLEN  source operands (rs1, rs2).
- `ALUControl_out`  out  4  combinational ALU code.
- `is_muldiv`  out  1  combinational; `ALUOp`=10 and `func7`=0000001.
- `stall`  out  1  combinational; `valid & is_muldiv & ~done`.
- `busy`  out  1  registered; FSM in BUSY.
- `done`  out  1  registered; one-cycle pulse, `muldiv_result` valid.
- `muldiv_result`  out  XLEN  registered M-op result, held until next start.

## Operation
ALU codes:
- AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SLT 0111, SRA 1000, SLTU 1001.

Decode by `ALUOp`:
- `ALUOp`=00: ADD.
- `ALUOp`=01: SUB.
- `ALUOp`=10: func3 000 gives ADD, or SUB when `func7[5]`=1. 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA when `func7[5]`). 110 OR, 111 AND.
- `ALUOp`=11: same as 10, except func3 000 is always ADD and `func7` is only examined for func3 101.
- Any `func7` other than 0000000/0100000/0000001 in R-type produces 0000.
- When `is_muldiv`, `ALUControl_out`=0000 (don't-care to ALU).

M-ops (func3): MUL 000, MULH 001, MULHSU 010, MULHU 011, DIV 100, DIVU 101, REM 110, REMU 111.

FSM states:
- IDLE: on `valid & is_muldiv`, latch operands/func3 (start edge).
  - If it is a fast-path case, go to DONE.
  - Otherwise load counter=XLEN and go to BUSY.
- BUSY: one shift-add (multiply) or restoring-subtract (divide) step per cycle on magnitudes; counter decrements.
  - At the edge where counter==1, write the sign-corrected result and go to DONE.
  - If `valid` is low at any edge in BUSY, abort and go to IDLE; `done` does not pulse and `muldiv_result` is unchanged.
- DONE: `done`=1 for exactly one cycle, then unconditionally IDLE.

Arithmetic rules:
- Multiply forms a 2·XLEN product. MUL returns the low half; MULH/MULHSU/MULHU return the high half.
- Signedness: MULH s×s, MULHSU s×u, MULHU u×u.
- Division truncates toward zero; the remainder takes the dividend's sign.
- Fast path (no iteration):
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give `op_a`.
  - Signed overflow (min-int / −1): DIV gives min-int; REM gives 0.

Reset values: `busy`, `done`, `muldiv_result`, counter all 0; FSM IDLE. Assertion mid-operation clears these immediately.

## Timing
- Decode path: zero latency, purely combinational.
- Normal M-op: `busy` high for XLEN cycles after the start edge. `done` is high in the cycle after edge XLEN. `stall` is high for XLEN+1 cycles.
- Fast path: `done` is high in the cycle after the start edge. `stall` is high for 1 cycle.
- The datapath advances on the edge that ends the `done` cycle. The FSM is in IDLE at that edge, so the next instruction can start at the following edge with no re-trigger.

## Structure
- Shared package `alu_pkg`:
  - ALU code constants.
  - ALUOp encodings.
  - func7 constants 0000000/0100000/0000001.
  - M-op func3 enum.
  - FSM state enum.
- Sub-module `muldiv_iter` holds the FSM, counter, operand/accumulator registers and sign fixup.
- Top holds the combinational decode and `stall`.

## Test plan
1. `ALUOp`=10, `func7`=0100000, `func3`=101 -> `ALUControl_out`=1000, `stall`=0. `ALUOp`=11, `func7`=0100000, `func3`=000 -> 0010.
2. MUL, a=7, b=0xFFFFFFFD (XLEN=32) -> `stall` high 33 cycles, `done` in the cycle after edge 32, result 0xFFFFFFEB.
3. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU 0xFFFFFFFF×2 -> 0xFFFFFFFF.
4. DIV 5/0 -> `done` the cycle after the start edge, 0xFFFFFFFF. REMU 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM same -> 0.
5. DIV −7/2 -> 0xFFFFFFFD. REM −7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU -> 2.
6. `rst_n` low in cycle 10 of MUL -> `busy`/`done`/`muldiv_result` 0 immediately. Separately, `valid` dropped in cycle 5 -> IDLE next edge, no `done` pulse.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU control encodings, M-op and FSM enums, and the base-ISA decode function.
// Purely combinational helpers; no latency, no backpressure.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        MOP_MUL    = 3'b000,
        MOP_MULH   = 3'b001,
        MOP_MULHSU = 3'b010,
        MOP_MULHU  = 3'b011,
        MOP_DIV    = 3'b100,
        MOP_DIVU   = 3'b101,
        MOP_REM    = 3'b110,
        MOP_REMU   = 3'b111
    } mop_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_e;

    function automatic logic [3:0] alu_decode(input logic [1:0] aluop,
                                              input logic [6:0] func7,
                                              input logic [2:0] func3);
        logic [3:0] code;
        code = ALU_ADD;
        case (aluop)
            ALUOP_MEM: code = ALU_ADD;
            ALUOP_BR:  code = ALU_SUB;
            default: begin
                case (func3)
                    3'b000:  code = (aluop == ALUOP_R && func7[5]) ? ALU_SUB : ALU_ADD;
                    3'b001:  code = ALU_SLL;
                    3'b010:  code = ALU_SLT;
                    3'b011:  code = ALU_SLTU;
                    3'b100:  code = ALU_XOR;
                    3'b101:  code = func7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  code = ALU_OR;
                    default: code = ALU_AND;
                endcase
                // Unknown func7 and M-ops both collapse to the AND code in R-type.
                if (aluop == ALUOP_R && func7 != F7_BASE && func7 != F7_ALT)
                    code = ALU_AND;
            end
        endcase
        return code;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative M-extension engine: XLEN-step shift-add multiply / restoring divide on magnitudes.
// Result XLEN+1 cycles after start (1 on fast path); dropping valid while busy aborts silently.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            valid,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    mop_e                op_q, op_d;
    logic                neg_q, neg_d;
    logic [XLEN-1:0]     result_q, result_d;

    mop_e                op_in;
    logic                a_signed, b_signed, sa, sb;
    logic [XLEN-1:0]     mag_a, mag_b;
    logic                div_zero, div_ovf;
    logic [XLEN-1:0]     fast_res;

    logic [XLEN:0]       mul_sum;
    logic [XLEN:0]       div_shift, div_diff;
    logic [2*XLEN-1:0]   mul_nxt, div_nxt, step;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     div_val, div_fix, final_res;

    always_comb begin
        op_in    = mop_e'(func3);
        a_signed = op_in inside {MOP_MULH, MOP_MULHSU, MOP_DIV, MOP_REM};
        b_signed = op_in inside {MOP_MULH, MOP_DIV, MOP_REM};
        sa       = a_signed & op_a[XLEN-1];
        sb       = b_signed & op_b[XLEN-1];
        mag_a    = sa ? -op_a : op_a;
        mag_b    = sb ? -op_b : op_b;
        div_zero = func3[2] && (op_b == '0);
        div_ovf  = (op_in == MOP_DIV || op_in == MOP_REM) && op_a == MIN_INT && op_b == '1;
        if (div_zero)
            fast_res = func3[1] ? op_a : '1;
        else
            fast_res = func3[1] ? '0 : MIN_INT;
    end

    // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_nxt   = {mul_sum, acc_q[XLEN-1:1]};
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (!div_diff[XLEN])
            div_nxt = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else
            div_nxt = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        step      = op_q[2] ? div_nxt : mul_nxt;

        prod_fix  = neg_q ? -step : step;
        div_val   = (op_q inside {MOP_REM, MOP_REMU}) ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];
        div_fix   = neg_q ? -div_val : div_val;
        if (op_q[2])
            final_res = div_fix;
        else if (op_q == MOP_MUL)
            final_res = prod_fix[XLEN-1:0];
        else
            final_res = prod_fix[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        op_d     = op_q;
        neg_d    = neg_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d   = op_in;
                    acc_d  = {{XLEN{1'b0}}, mag_a};
                    opnd_d = mag_b;
                    neg_d  = (op_in inside {MOP_REM, MOP_REMU}) ? sa : (sa ^ sb);
                    if (div_zero || div_ovf) begin
                        result_d = fast_res;
                        state_d  = S_DONE;
                    end else begin
                        cnt_d   = CW'(XLEN);
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (!valid) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    acc_d = step;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        result_d = final_res;
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            op_q     <= MOP_MUL;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == S_BUSY);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: rtl/alu_control_mc.sv
// Execute-stage ALU control: combinational decode plus a stall while an M-op iterates.
// Decode has zero latency; stall holds the pipeline until the done cycle of an M-op.
module alu_control_mc
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      ALUOp,
    input  logic [6:0]      func7,
    input  logic [2:0]      func3,
    input  logic            valid,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [3:0]      ALUControl_out,
    output logic            is_muldiv,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] muldiv_result
);

    assign is_muldiv      = (ALUOp == ALUOP_R) && (func7 == F7_MULDIV);
    assign ALUControl_out = alu_decode(ALUOp, func7, func3);
    assign stall          = valid & is_muldiv & ~done;

    muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (valid & is_muldiv),
        .valid  (valid),
        .func3  (func3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (muldiv_result)
    );

endmodule

// File: tb/tb_alu_control_mc.sv
// Randomised bench for alu_control_mc against a cycle-level behavioural model of the stage.
module tb_alu_control_mc;

    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  ALUOp = 2'b00;
    logic [6:0]  func7 = 7'd0;
    logic [2:0]  func3 = 3'd0;
    logic        valid = 1'b0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic [3:0]  ALUControl_out;
    logic        is_muldiv, stall, busy, done;
    logic [31:0] muldiv_result;

    int n_checks = 0;
    int n_err = 0;

    alu_control_mc #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .ALUOp(ALUOp), .func7(func7), .func3(func3),
        .valid(valid), .op_a(op_a), .op_b(op_b), .ALUControl_out(ALUControl_out),
        .is_muldiv(is_muldiv), .stall(stall), .busy(busy), .done(done),
        .muldiv_result(muldiv_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic exp_md(input logic [1:0] aop, input logic [6:0] f7);
        return aop == 2'b10 && f7 == 7'b0000001;
    endfunction

    function automatic logic [3:0] exp_alu(input logic [1:0] aop, input logic [6:0] f7,
                                           input logic [2:0] f3);
        logic [3:0] base [8];
        base = '{4'b0010, 4'b0100, 4'b0111, 4'b1001, 4'b0011, 4'b0101, 4'b0001, 4'b0000};
        if (aop == 2'b00) return 4'b0010;
        if (aop == 2'b01) return 4'b0110;
        if (aop == 2'b10 && !(f7 == 7'h00 || f7 == 7'h20)) return 4'b0000;
        if (f3 == 3'd5 && f7[5]) return 4'b1000;
        if (f3 == 3'd0 && aop == 2'b10 && f7 == 7'h20) return 4'b0110;
        return base[f3];
    endfunction

    function automatic logic is_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return f3[2] && (b == 0 || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
    endfunction

    function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        int          ia, ib;
        longint      la, lb, ps;
        logic [63:0] pu;
        ia = a; ib = b; la = ia; lb = ib;
        case (f3)
            3'd0: begin pu = {32'd0, a} * {32'd0, b}; return pu[31:0]; end
            3'd1: begin ps = la * lb; pu = ps; return pu[63:32]; end
            3'd2: begin ps = la * longint'({32'd0, b}); pu = ps; return pu[63:32]; end
            3'd3: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    int          m_left;
    logic        m_done;
    logic [31:0] m_res, m_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_res  <= 32'd0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_left > 0) begin
            if (!valid) m_left <= 0;
            else if (m_left == 1) begin
                m_left <= 0;
                m_done <= 1'b1;
                m_res  <= m_pend;
            end else m_left <= m_left - 1;
        end else if (valid && exp_md(ALUOp, func7)) begin
            m_pend <= ref_md(func3, op_a, op_b);
            if (is_fast(func3, op_a, op_b)) begin
                m_done <= 1'b1;
                m_res  <= ref_md(func3, op_a, op_b);
            end else m_left <= XLEN;
        end
    end

    always @(negedge clk) begin
        logic emd;
        emd = exp_md(ALUOp, func7);
        chk("is_muldiv", 64'(is_muldiv), 64'(emd));
        chk("alu_code", 64'(ALUControl_out), emd ? 64'd0 : 64'(exp_alu(ALUOp, func7, func3)));
        chk("stall", 64'(stall), 64'(valid && emd && !m_done));
        chk("busy", 64'(busy), 64'(m_left > 0));
        chk("done", 64'(done), 64'(m_done));
        chk("result", 64'(muldiv_result), 64'(m_res));
    end

    // ---------------- stimulus ----------------
    task automatic run_op(input logic [1:0] aop, input logic [6:0] f7, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b, input int drop_at,
                          output int nst);
        int   cyc;
        logic st;
        ALUOp = aop; func7 = f7; func3 = f3; op_a = a; op_b = b; valid = 1'b1;
        nst = 0; cyc = 0;
        forever begin
            @(negedge clk);
            st = stall;
            if (st) nst++;
            @(posedge clk);
            #2;
            cyc++;
            if (!st) break;
            if (drop_at > 0 && cyc == drop_at) begin
                valid = 1'b0;
                @(posedge clk);
                #2;
                break;
            end
            if (cyc > 200) begin
                n_checks++;
                n_err++;
                $display("FAIL op_timeout: stall still high after %0d cycles", cyc);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 20));
            4: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          nst;
        logic [31:0] prev;
        logic [1:0]  aop;
        logic [6:0]  f7;

        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", 64'(muldiv_result), 64'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // model anchors
        chk("model_mulhu", 64'(ref_md(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF)), 64'hFFFFFFFE);
        chk("model_mulhsu", 64'(ref_md(3'd2, 32'hFFFFFFFF, 32'd2)), 64'hFFFFFFFF);
        chk("model_rem", 64'(ref_md(3'd6, -32'd7, 32'd2)), 64'hFFFFFFFF);

        ALUOp = 2'b10; func7 = 7'h20; func3 = 3'd5; valid = 1'b1;
        #1;
        chk("dec_sra", 64'(ALUControl_out), 64'b1000);
        chk("dec_sra_stall", 64'(stall), 64'd0);
        ALUOp = 2'b11; func7 = 7'h20; func3 = 3'd0;
        #1;
        chk("dec_iadd", 64'(ALUControl_out), 64'b0010);
        @(posedge clk);
        #2;

        run_op(2'b10, 7'h01, 3'd0, 32'd7, 32'hFFFFFFFD, 0, nst);
        chk("mul_stall_cycles", 64'(nst), 64'd33);
        chk("mul_res", 64'(muldiv_result), 64'hFFFFFFEB);
        run_op(2'b10, 7'h01, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, nst);
        chk("mulhu_res", 64'(muldiv_result), 64'hFFFFFFFE);
        run_op(2'b10, 7'h01, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, nst);
        chk("mulh_res", 64'(muldiv_result), 64'h0);
        run_op(2'b10, 7'h01, 3'd2, 32'hFFFFFFFF, 32'd2, 0, nst);
        chk("mulhsu_res", 64'(muldiv_result), 64'hFFFFFFFF);
        run_op(2'b10, 7'h01, 3'd4, 32'd5, 32'd0, 0, nst);
        chk("div0_stall_cycles", 64'(nst), 64'd1);
        chk("div0_res", 64'(muldiv_result), 64'hFFFFFFFF);
        run_op(2'b10, 7'h01, 3'd7, 32'd5, 32'd0, 0, nst);
        chk("remu0_res", 64'(muldiv_result), 64'd5);
        run_op(2'b10, 7'h01, 3'd4, 32'h80000000, 32'hFFFFFFFF, 0, nst);
        chk("div_ovf_res", 64'(muldiv_result), 64'h80000000);
        chk("div_ovf_stall", 64'(nst), 64'd1);
        run_op(2'b10, 7'h01, 3'd6, 32'h80000000, 32'hFFFFFFFF, 0, nst);
        chk("rem_ovf_res", 64'(muldiv_result), 64'd0);
        run_op(2'b10, 7'h01, 3'd4, -32'd7, 32'd2, 0, nst);
        chk("div_neg_res", 64'(muldiv_result), 64'hFFFFFFFD);
        run_op(2'b10, 7'h01, 3'd6, -32'd7, 32'd2, 0, nst);
        chk("rem_neg_res", 64'(muldiv_result), 64'hFFFFFFFF);
        run_op(2'b10, 7'h01, 3'd5, 32'd100, 32'd7, 0, nst);
        chk("divu_res", 64'(muldiv_result), 64'd14);
        run_op(2'b10, 7'h01, 3'd7, 32'd100, 32'd7, 0, nst);
        chk("remu_res", 64'(muldiv_result), 64'd2);

        // reset in the middle of a multiply
        ALUOp = 2'b10; func7 = 7'h01; func3 = 3'd0; op_a = 32'd9; op_b = 32'd11; valid = 1'b1;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_result", 64'(muldiv_result), 64'd0);
        valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        idle(1);

        // abort by dropping valid
        run_op(2'b10, 7'h01, 3'd0, 32'd3, 32'd4, 0, nst);
        prev = muldiv_result;
        run_op(2'b10, 7'h01, 3'd5, 32'd1000, 32'd3, 5, nst);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_result", 64'(muldiv_result), 64'(prev));
        idle(2);

        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 9) < 4) begin
                aop = 2'b10;
                f7  = 7'h01;
            end else begin
                aop = 2'($urandom_range(0, 3));
                case ($urandom_range(0, 3))
                    0: f7 = 7'h00;
                    1: f7 = 7'h20;
                    2: f7 = 7'h01;
                    default: f7 = 7'($urandom);
                endcase
            end
            run_op(aop, f7, 3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd(),
                   ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 30)) : 0, nst);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        end
        idle(3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end

endmodule
